// File: rtl/amo_sequencer_if.sv
// Bundle of every signal the atomic sequencer exchanges with the core,
// the data-memory port, the shared ALU and the snoop bus.
// The sequencer connects through "slave"; its environment uses "master".
interface amo_sequencer_if #(
    parameter int ADDR_W = 32
);
    // Request from the execute stage
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_kind;
    logic [15:0]       req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;

    // Response back to the core
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;

    // Data-memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // Shared ALU
    logic [31:0]       alu_in1;
    logic [31:0]       alu_in2;
    logic [15:0]       alu_op;
    logic [63:0]       alu_result;

    // Writes by other masters
    logic              snoop_valid;
    logic [ADDR_W-1:0] snoop_addr;

    modport slave (
        input  req_valid, req_kind, req_op, req_addr, req_data,
        output req_ready,
        output resp_valid, resp_data, resp_err,
        input  resp_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output alu_in1, alu_in2, alu_op,
        input  alu_result,
        input  snoop_valid, snoop_addr
    );

    modport master (
        output req_valid, req_kind, req_op, req_addr, req_data,
        input  req_ready,
        input  resp_valid, resp_data, resp_err,
        output resp_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  alu_in1, alu_in2, alu_op,
        output alu_result,
        output snoop_valid, snoop_addr
    );
endinterface

// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: read, one ALU pass, write-back, and the single
// LR/SC reservation. All outputs are decoded from registered state only,
// so no request/memory input reaches an output combinationally.
module amo_sequencer #(
    parameter int ADDR_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    amo_sequencer_if.slave    bus
);

    localparam logic [1:0] KIND_AMO = 2'b00;
    localparam logic [1:0] KIND_LR  = 2'b01;
    localparam logic [1:0] KIND_SC  = 2'b10;
    localparam logic [1:0] KIND_BAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EXEC = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Opcodes the sequencer will hand to the ALU for an AMO.
    function automatic logic op_is_legal(input logic [15:0] op);
        logic legal;
        case (op)
            16'h0001, 16'h0004, 16'h0008, 16'h0010,
            16'h2000, 16'h4000, 16'h8000: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          kind_q, kind_d;
    logic [15:0]         op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         old_q, old_d;
    logic [31:0]         new_q, new_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                res_valid_q, res_valid_d;
    logic [ADDR_W-3:0]   res_addr_q, res_addr_d;

    logic                req_bad_s;
    logic                snoop_hit_res_s;
    logic                snoop_hit_cur_s;
    logic                res_set_s;
    logic                res_clr_s;
    logic                unused_bits_s;

    // Upper ALU half and snoop byte offset carry no information here.
    assign unused_bits_s = ^{bus.alu_result[63:32], bus.snoop_addr[1:0]};

    // Classify the incoming request and the snoop bus against the reservation.
    always_comb begin
        req_bad_s       = (bus.req_addr[1:0] != 2'b00) ||
                          (bus.req_kind == KIND_BAD) ||
                          ((bus.req_kind == KIND_AMO) && !op_is_legal(bus.req_op));
        snoop_hit_res_s = bus.snoop_valid && res_valid_q &&
                          (bus.snoop_addr[ADDR_W-1:2] == res_addr_q);
        snoop_hit_cur_s = bus.snoop_valid &&
                          (bus.snoop_addr[ADDR_W-1:2] == addr_q[ADDR_W-1:2]);
    end

    // Next-state logic of the sequencing FSM and its data latches.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        old_d     = old_q;
        new_d     = new_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        res_set_s = 1'b0;
        res_clr_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    kind_d  = bus.req_kind;
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    data_d  = bus.req_data;
                    err_d   = 1'b0;
                    rdata_d = 32'd0;
                    if (req_bad_s) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (bus.req_kind == KIND_SC) begin
                        // A same-cycle snoop hit wins over the SC.
                        if (res_valid_q && !snoop_hit_res_s &&
                            (res_addr_q == bus.req_addr[ADDR_W-1:2])) begin
                            res_clr_s = 1'b1;
                            state_d   = ST_WR;
                        end else begin
                            rdata_d = 32'd1;
                            state_d = ST_RESP;
                        end
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (bus.mem_ack) begin
                    old_d = bus.mem_rdata;
                    if (kind_q == KIND_LR) begin
                        rdata_d = bus.mem_rdata;
                        // A write by someone else racing the LR leaves no reservation.
                        if (snoop_hit_cur_s) begin
                            res_clr_s = 1'b1;
                        end else begin
                            res_set_s = 1'b1;
                        end
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_EXEC: begin
                new_d   = bus.alu_result[31:0];
                state_d = ST_WR;
            end
            ST_WR: begin
                if (bus.mem_ack) begin
                    if (kind_q == KIND_AMO) begin
                        rdata_d = old_q;
                        if (res_valid_q && (res_addr_q == addr_q[ADDR_W-1:2])) begin
                            res_clr_s = 1'b1;
                        end else begin
                            res_clr_s = 1'b0;
                        end
                    end else begin
                        rdata_d = 32'd0;
                    end
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reservation update: set by LR, cleared by snoop hit, SC success or AMO write.
    always_comb begin
        res_valid_d = res_valid_q;
        res_addr_d  = res_addr_q;
        if (res_set_s) begin
            res_valid_d = 1'b1;
            res_addr_d  = addr_q[ADDR_W-1:2];
        end else if (res_clr_s || snoop_hit_res_s) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kind_q      <= 2'b00;
            op_q        <= 16'd0;
            addr_q      <= {ADDR_W{1'b0}};
            data_q      <= 32'd0;
            old_q       <= 32'd0;
            new_q       <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= {(ADDR_W-2){1'b0}};
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            old_q       <= old_d;
            new_q       <= new_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
        end
    end

    // Output decode from the registered state; everything idles at zero.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = 32'd0;
        bus.resp_err   = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = {ADDR_W{1'b0}};
        bus.mem_wdata  = 32'd0;
        bus.alu_in1    = 32'd0;
        bus.alu_in2    = 32'd0;
        bus.alu_op     = 16'd0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
            end
            ST_RD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr_q;
            end
            ST_EXEC: begin
                bus.alu_in1 = old_q;
                bus.alu_in2 = data_q;
                bus.alu_op  = op_q;
            end
            ST_WR: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = addr_q;
                if (kind_q == KIND_SC) begin
                    bus.mem_wdata = data_q;
                end else begin
                    bus.mem_wdata = new_q;
                end
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = rdata_q;
                bus.resp_err   = err_q;
            end
            default: begin
                bus.req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer: memory with programmable wait states,
// a reference ALU, and immediate-assertion checks on each step.
module tb_amo_sequencer;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    amo_sequencer_if #(.ADDR_W(AW)) bus();
    amo_sequencer #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] mem [0:1023];
    int          ack_wait = 0;
    int          wait_cnt = 0;
    int          memreq_cycles = 0;
    int          alu_cycles = 0;
    int          stab_err = 0;
    logic [15:0] alu_op_seen = 16'd0;
    logic [31:0] last_wr_addr = 32'd0;
    logic        prev_req = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_wdata = 32'd0;
    int          total = 0;
    int          passed = 0;

    // Reference ALU (unsigned max/min)
    function automatic logic [31:0] alu_model(input logic [15:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            16'h0001: return a + b;
            16'h0004: return a ^ b;
            16'h0008: return a | b;
            16'h0010: return a & b;
            16'h2000: return b;
            16'h4000: return (a > b) ? a : b;
            16'h8000: return (a < b) ? a : b;
            default:  return 32'd0;
        endcase
    endfunction

    assign bus.alu_result = {32'd0, alu_model(bus.alu_op, bus.alu_in1, bus.alu_in2)};
    assign bus.mem_ack    = bus.mem_req && (wait_cnt == ack_wait);
    assign bus.mem_rdata  = mem[bus.mem_addr[11:2]];

    // Memory model, wait-state counter and bus monitors
    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (bus.mem_req) memreq_cycles <= memreq_cycles + 1;
        if (bus.alu_op != 16'd0) begin
            alu_cycles  <= alu_cycles + 1;
            alu_op_seen <= bus.alu_op;
        end
        if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
            last_wr_addr <= bus.mem_addr;
        end
        if (prev_req && bus.mem_req &&
            ((bus.mem_addr != prev_addr) || (bus.mem_wdata != prev_wdata) || (bus.mem_we != prev_we)))
            stab_err <= stab_err + 1;
        prev_req   <= bus.mem_req;
        prev_we    <= bus.mem_we;
        prev_addr  <= bus.mem_addr;
        prev_wdata <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one request from IDLE and return cycles until resp_valid.
    task automatic run_req(input logic [1:0] kind, input logic [15:0] op,
                           input logic [31:0] addr, input logic [31:0] data,
                           output int lat);
        bus.req_valid = 1'b1;
        bus.req_kind  = kind;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_resp();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int m0;
        int a0;
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        bus.req_valid   = 1'b0;
        bus.req_kind    = 2'b00;
        bus.req_op      = 16'd0;
        bus.req_addr    = 32'd0;
        bus.req_data    = 32'd0;
        bus.resp_ready  = 1'b0;
        bus.snoop_valid = 1'b0;
        bus.snoop_addr  = 32'd0;

        // Reset state
        #12;
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
        chk("rst_alu_op", {48'd0, bus.alu_op}, 64'd0);
        chk("rst_resp_data", {32'd0, bus.resp_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // AMOADD zero-wait: 5 + 3
        mem[64] = 32'd5;
        m0 = memreq_cycles; a0 = alu_cycles;
        run_req(2'b00, 16'h0001, 32'h100, 32'd3, lat);
        chk("add_latency", 64'(lat), 64'd4);
        chk("add_resp", {32'd0, bus.resp_data}, 64'd5);
        chk("add_err", {63'd0, bus.resp_err}, 64'd0);
        chk("add_mem", {32'd0, mem[64]}, 64'd8);
        chk("add_wr_addr", {32'd0, last_wr_addr}, 64'h100);
        chk("add_alu_cycles", 64'(alu_cycles - a0), 64'd1);
        chk("add_alu_op", {48'd0, alu_op_seen}, 64'd1);
        chk("add_memreq_cycles", 64'(memreq_cycles - m0), 64'd2);
        finish_resp();

        // LR then SC success then SC fail
        mem[128] = 32'h11;
        run_req(2'b01, 16'd0, 32'h200, 32'd0, lat);
        chk("lr_latency", 64'(lat), 64'd2);
        chk("lr_resp", {32'd0, bus.resp_data}, 64'h11);
        finish_resp();
        run_req(2'b10, 16'd0, 32'h200, 32'h22, lat);
        chk("sc_ok_latency", 64'(lat), 64'd2);
        chk("sc_ok_resp", {32'd0, bus.resp_data}, 64'd0);
        chk("sc_ok_mem", {32'd0, mem[128]}, 64'h22);
        finish_resp();
        m0 = memreq_cycles;
        run_req(2'b10, 16'd0, 32'h200, 32'h33, lat);
        chk("sc2_latency", 64'(lat), 64'd1);
        chk("sc2_resp", {32'd0, bus.resp_data}, 64'd1);
        chk("sc2_no_mem", 64'(memreq_cycles - m0), 64'd0);
        finish_resp();

        // Snoop kills reservation
        mem[192] = 32'h33;
        run_req(2'b01, 16'd0, 32'h300, 32'd0, lat);
        chk("lr3_resp", {32'd0, bus.resp_data}, 64'h33);
        finish_resp();
        bus.snoop_valid = 1'b1;
        bus.snoop_addr  = 32'h302;
        @(negedge clk);
        bus.snoop_valid = 1'b0;
        m0 = memreq_cycles;
        run_req(2'b10, 16'd0, 32'h300, 32'h44, lat);
        chk("snoop_sc_latency", 64'(lat), 64'd1);
        chk("snoop_sc_resp", {32'd0, bus.resp_data}, 64'd1);
        chk("snoop_sc_no_mem", 64'(memreq_cycles - m0), 64'd0);
        chk("snoop_sc_mem", {32'd0, mem[192]}, 64'h33);
        finish_resp();

        // Errors: misaligned, illegal op, illegal kind
        m0 = memreq_cycles;
        run_req(2'b00, 16'h0001, 32'h101, 32'd3, lat);
        chk("mis_latency", 64'(lat), 64'd1);
        chk("mis_err", {63'd0, bus.resp_err}, 64'd1);
        chk("mis_data", {32'd0, bus.resp_data}, 64'd0);
        finish_resp();
        run_req(2'b00, 16'h0002, 32'h100, 32'd3, lat);
        chk("badop_err", {63'd0, bus.resp_err}, 64'd1);
        chk("badop_data", {32'd0, bus.resp_data}, 64'd0);
        finish_resp();
        run_req(2'b11, 16'h0001, 32'h100, 32'd3, lat);
        chk("badkind_err", {63'd0, bus.resp_err}, 64'd1);
        finish_resp();
        chk("err_no_mem", 64'(memreq_cycles - m0), 64'd0);

        // AMOMAX with 3 wait cycles per access and 2 cycles of backpressure
        mem[256] = 32'd7;
        ack_wait = 3;
        run_req(2'b00, 16'h4000, 32'h400, 32'd9, lat);
        chk("max_latency", 64'(lat), 64'd10);
        chk("max_resp", {32'd0, bus.resp_data}, 64'd7);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("max_hold_valid", {63'd0, bus.resp_valid}, 64'd1);
            chk("max_hold_data", {32'd0, bus.resp_data}, 64'd7);
        end
        chk("max_mem", {32'd0, mem[256]}, 64'd9);
        chk("max_stable", 64'(stab_err), 64'd0);
        finish_resp();
        ack_wait = 0;

        // AMOMINU treats 0xFFFFFFFF as the largest value
        mem[257] = 32'hFFFF_FFFF;
        run_req(2'b00, 16'h8000, 32'h404, 32'd2, lat);
        chk("minu_resp", {32'd0, bus.resp_data}, 64'hFFFF_FFFF);
        chk("minu_mem", {32'd0, mem[257]}, 64'd2);
        finish_resp();

        // AMO to the reserved word kills the reservation
        mem[448] = 32'h70;
        run_req(2'b01, 16'd0, 32'h700, 32'd0, lat);
        finish_resp();
        run_req(2'b00, 16'h2000, 32'h700, 32'h77, lat);
        chk("swap_resp", {32'd0, bus.resp_data}, 64'h70);
        chk("swap_mem", {32'd0, mem[448]}, 64'h77);
        finish_resp();
        run_req(2'b10, 16'd0, 32'h700, 32'h78, lat);
        chk("sc_after_amo", {32'd0, bus.resp_data}, 64'd1);
        finish_resp();

        // Reset in the middle of WR
        mem[320] = 32'h50;
        mem[384] = 32'd1;
        run_req(2'b01, 16'd0, 32'h500, 32'd0, lat);
        chk("lr5_resp", {32'd0, bus.resp_data}, 64'h50);
        finish_resp();
        ack_wait = 5;
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'b00;
        bus.req_op    = 16'h0001;
        bus.req_addr  = 32'h600;
        bus.req_data  = 32'd1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.mem_we && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("wr_reached", {63'd0, bus.mem_we}, 64'd1);
        chk("wr_wdata", {32'd0, bus.mem_wdata}, 64'd2);
        chk("wr_addr", {32'd0, bus.mem_addr}, 64'h600);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("midrst_mem_req", {63'd0, bus.mem_req}, 64'd0);
        chk("midrst_outs", {bus.mem_addr, bus.mem_wdata}, 64'd0);
        chk("midrst_we_valid", {62'd0, bus.mem_we, bus.resp_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_wait = 0;
        @(negedge clk);
        chk("postrst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("postrst_mem_req", {63'd0, bus.mem_req}, 64'd0);
        chk("postrst_mem_unwritten", {32'd0, mem[384]}, 64'd1);
        run_req(2'b10, 16'd0, 32'h500, 32'h55, lat);
        chk("postrst_sc_latency", 64'(lat), 64'd1);
        chk("postrst_sc_resp", {32'd0, bus.resp_data}, 64'd1);
        chk("postrst_sc_mem", {32'd0, mem[320]}, 64'h50);
        finish_resp();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/amo_sequencer.md
# amo_sequencer

Multi-cycle controller that executes RV32A atomic operations (AMO*.W, LR.W, SC.W) by sequencing a memory read, one pass through the shared `alu`, and a memory write-back. It sits between the core's execute stage and the data-memory port. It holds the single LR/SC reservation and is the only agent that drives the `alu` operand and opcode lines during atomics.

## Interface
Parameters:
- `ADDR_W`, default 32: memory address width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  atomic request present.
- `req_ready`  out  1  sequencer can accept a request (high only in IDLE).
- `req_kind`  in  2  00 AMO, 01 LR, 10 SC, 11 illegal.
- `req_op`  in  16  one-hot `alu` opcode for AMO. Legal values: 1 add, 4 xor, 8 or, 16 and, 8192 swap, 16384 max, 32768 min.
- `req_addr`  in  ADDR_W  word address from rs1.
- `req_data`  in  32  rs2 value.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_data`  out  32  value written to rd.
- `resp_err`  out  1  request was misaligned or illegal.
- `mem_req`  out  1  memory transaction active.
- `mem_we`  out  1  1 write, 0 read.
- `mem_addr`  out  ADDR_W  transaction address.
- `mem_wdata`  out  32  write data.
- `mem_ack`  in  1  transaction complete this cycle.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.
- `alu_in1`, `alu_in2`  out  32  ALU operands.
- `alu_op`  out  16  ALU opcode.
- `alu_result`  in  64  ALU output; only bits [31:0] are used.
- `snoop_valid`  in  1  another master is writing memory.
- `snoop_addr`  in  ADDR_W  address of that write.

## Operation
- FSM states: IDLE, RD, EXEC, WR, RESP.
- IDLE:
  - `req_ready`=1. On `req_valid`, latch kind, op, addr and data.
  - Error case: `req_addr[1:0]`≠0, kind=11, or an AMO with an op outside the legal set. Go to RESP with `resp_err`=1 and `resp_data`=0. No memory access occurs.
  - LR or AMO: go to RD.
  - SC with reservation valid and `res_addr[ADDR_W-1:2]`==`req_addr[ADDR_W-1:2]`: clear the reservation and go to WR.
  - SC otherwise: go to RESP with `resp_data`=1. No memory access occurs.
- RD: `mem_req`=1, `mem_we`=0, `mem_addr`=latched addr, held until `mem_ack`. On ack, latch `old`=`mem_rdata`.
  - LR: set the reservation (`res_addr`=addr, valid=1), `resp_data`=old, go to RESP.
  - AMO: go to EXEC.
- EXEC: exactly one cycle. `alu_in1`=old, `alu_in2`=rs2, `alu_op`=op. Latch `new`=`alu_result[31:0]` at the clock edge, then go to WR.
- WR: `mem_req`=1, `mem_we`=1. `mem_wdata` is `new` for AMO and rs2 for SC. Held until `mem_ack`, then go to RESP.
  - AMO result: `resp_data`=old.
  - SC result: `resp_data`=0.
  - An AMO to the reserved word clears the reservation.
- RESP: `resp_valid`=1, `resp_data` and `resp_err` stable until `resp_ready`, then go to IDLE.
- Outside EXEC, `alu_in1`, `alu_in2` and `alu_op` are all 0.
- MAX and MIN are unsigned, matching `alu` semantics. AMOMAXU and AMOMINU map to the same codes.
- Reservation: one entry of address plus valid bit.
  - Cleared by a snoop hit (`snoop_valid` and word address match), by reset, by a successful SC, and by an AMO write to the same word.
  - A snoop hit in the same cycle an SC is accepted in IDLE takes priority: the SC fails.
  - A snoop hit in the same cycle as the LR ack: the reservation is not set.
- While `mem_req`=1, `mem_addr`, `mem_we` and `mem_wdata` do not change.

## Timing
- Reset values: state IDLE, `req_ready`=1, reservation invalid. All other outputs are 0.
- Asserting `rst_n` mid-operation aborts immediately to IDLE. Any in-flight memory transaction is abandoned, and the memory side must tolerate `mem_req` dropping without an ack.
- `mem_ack` counts when sampled high in any cycle with `mem_req`=1, including the first.
- With zero-wait memory (ack in the first cycle), measured from the acceptance edge:
  - AMO: `resp_valid` rises 4 cycles later (RD, EXEC, WR, RESP).
  - LR: 2 cycles.
  - SC success: 2 cycles.
  - SC fail or error: 1 cycle.
- Each memory wait cycle adds one cycle to latency.
- Back-to-back throughput: one request per (latency + 1) cycles. The next request is accepted in the IDLE cycle after the `resp_ready` handshake.
- `req_ready` is 0 in every state except IDLE. No request is ever dropped.

## Test plan
- AMOADD: mem[0x100]=5, `req_data`=3, op=1, zero-wait memory. Expect `resp_data`=5 four cycles after accept, a write of 8 to 0x100, and `alu_op`=1 only during EXEC.
- LR then SC: LR 0x200 (mem=0x11) returns 0x11. SC 0x200 with `req_data`=0x22 writes 0x22 and returns 0. A second SC to 0x200 returns 1 with no memory access.
- Snoop kill: LR 0x300, then `snoop_valid` with `snoop_addr`=0x302. The next SC 0x300 returns 1 and `mem_req` stays 0.
- Errors: `req_addr`=0x101 with AMO add, or op=2 (sub). Expect `resp_err`=1, `resp_data`=0, no `mem_req`.
- Wait states and backpressure: AMOMAX with mem=7, rs2=9, 3-cycle `mem_ack` delay, `resp_ready` low for 2 cycles. Expect write 9, `resp_data`=7 held stable, `mem_addr` and `mem_wdata` stable while waiting.
- Reset mid-WR: assert `rst_n`=0 during WR. Expect all outputs 0 and `req_ready`=1 after release, and a following SC fails.
